// File: rtl/gate_sched_pkg.sv
// Shared types for the gate operation scheduler.
// Holds the opcode width, the opcode enum and the scheduler FSM state enum.
package gate_sched_pkg;

    localparam int unsigned OP_W = 3;

    // Opcodes 6 and 7 are not listed; they are reported as illegal.
    typedef enum logic [OP_W-1:0] {
        OP_NOT  = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_MUX  = 3'd4,
        OP_DMUX = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_EXEC  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/gate_op_scheduler_rr_pick.sv
// Combinational round-robin selector.
// Ports: req (request vector), ptr (search start) -> found_c, winner_c
// (first requester with req high, searching upward from ptr with wrap).
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            found_c,
    output logic [IDW-1:0]  winner_c
);

    logic [IDW:0] idx;

    // Walk downward in distance so the closest requester to ptr wins last.
    always_comb begin
        found_c  = 1'b0;
        winner_c = '0;
        idx      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ)) begin
                idx = idx - (IDW+1)'(NREQ);
            end
            if (req[idx[IDW-1:0]]) begin
                found_c  = 1'b1;
                winner_c = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/gate_prims.sv
// Primitive 1-bit logic gates making up the shared gate bank.
// Ports: a, b, sel operand inputs; y (or y0/y1 for the demux) outputs.
module gate_not (
    input  logic a,
    output logic y
);
    assign y = ~a;
endmodule

module gate_and (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

module gate_or (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

module gate_xor (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

module gate_mux (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);
    assign y = sel ? b : a;
endmodule

module gate_dmux (
    input  logic a,
    input  logic sel,
    output logic y0,
    output logic y1
);
    assign y0 = sel ? 1'b0 : a;
    assign y1 = sel ? a : 1'b0;
endmodule

// File: rtl/gate_op_scheduler.sv
// Round-robin scheduler sharing one bank of 1-bit logic gates between NREQ
// requesters. Ports: clk, reset (sync, active-high); req/req_op/req_a/req_b/
// req_sel per-requester request and operands; gnt one-hot grant pulse; busy;
// resp_valid/resp_id/resp_out/resp_err tagged registered result.
module gate_op_scheduler
    import gate_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [OP_W*NREQ-1:0] req_op,
    input  logic [NREQ-1:0]      req_a,
    input  logic [NREQ-1:0]      req_b,
    input  logic [NREQ-1:0]      req_sel,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic                 resp_valid,
    output logic [IDW-1:0]       resp_id,
    output logic [1:0]           resp_out,
    output logic                 resp_err
);

    state_e            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              a_q, a_d, b_q, b_d, sel_q, sel_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic              resp_valid_q, resp_valid_d;
    logic [IDW-1:0]    resp_id_q, resp_id_d;
    logic [1:0]        resp_out_q, resp_out_d;
    logic              resp_err_q, resp_err_d;

    logic              found_c;
    logic [IDW-1:0]    winner_c;
    logic [1:0]        gate_out_c;
    logic              gate_err_c;
    logic              not_y, and_y, or_y, xor_y, mux_y, dmux_y0, dmux_y1;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req      (req),
        .ptr      (ptr_q),
        .found_c  (found_c),
        .winner_c (winner_c)
    );

    // Shared gate bank, driven only by the captured operands.
    gate_not  u_not  (.a(a_q), .y(not_y));
    gate_and  u_and  (.a(a_q), .b(b_q), .y(and_y));
    gate_or   u_or   (.a(a_q), .b(b_q), .y(or_y));
    gate_xor  u_xor  (.a(a_q), .b(b_q), .y(xor_y));
    gate_mux  u_mux  (.a(a_q), .b(b_q), .sel(sel_q), .y(mux_y));
    gate_dmux u_dmux (.a(a_q), .sel(sel_q), .y0(dmux_y0), .y1(dmux_y1));

    // Opcode-selected gate result.
    always_comb begin
        gate_out_c = '0;
        gate_err_c = 1'b0;
        case (op_e'(op_q))
            OP_NOT:  gate_out_c = {1'b0, not_y};
            OP_AND:  gate_out_c = {1'b0, and_y};
            OP_OR:   gate_out_c = {1'b0, or_y};
            OP_XOR:  gate_out_c = {1'b0, xor_y};
            OP_MUX:  gate_out_c = {1'b0, mux_y};
            OP_DMUX: gate_out_c = {dmux_y1, dmux_y0};
            default: gate_err_c = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (found_c) state_d = ST_GRANT;
            ST_GRANT: state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        ptr_d        = ptr_q;
        id_d         = id_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        sel_d        = sel_q;
        gnt_d        = '0;
        busy_d       = (state_d != ST_IDLE);
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id_q;
        resp_out_d   = resp_out_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (found_c) begin
                    id_d  = winner_c;
                    gnt_d = NREQ'(1) << winner_c;
                end
            end
            ST_GRANT: begin
                for (int i = 0; i < NREQ; i++) begin
                    if (id_q == IDW'(i)) begin
                        op_d  = req_op[i*OP_W +: OP_W];
                        a_d   = req_a[i];
                        b_d   = req_b[i];
                        sel_d = req_sel[i];
                    end
                end
                ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
            end
            ST_EXEC: begin
                resp_valid_d = 1'b1;
                resp_id_d    = id_q;
                resp_out_d   = gate_out_c;
                resp_err_d   = gate_err_c;
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q        <= '0;
            id_q         <= '0;
            op_q         <= '0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            sel_q        <= 1'b0;
            gnt_q        <= '0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_out_q   <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sel_q        <= sel_d;
            gnt_q        <= gnt_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_out_q   <= resp_out_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign gnt        = gnt_q;
    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_out   = resp_out_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_gate_op_scheduler.sv
// Self-checking bench for gate_op_scheduler: a timing-rule model predicts
// every output each cycle; directed scenarios add literal expectations.
module tb_gate_op_scheduler;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [NREQ-1:0]  req, req_a, req_b, req_sel;
    logic [3*NREQ-1:0] req_op;
    logic [NREQ-1:0]  gnt;
    logic             busy, resp_valid, resp_err;
    logic [IDW-1:0]   resp_id;
    logic [1:0]       resp_out;

    always #5 clk = ~clk;

    gate_op_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sel    (req_sel),
        .gnt        (gnt),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_out   (resp_out),
        .resp_err   (resp_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Opcode table: returns {err, out1, out0}.
    function automatic logic [2:0] eval_op(input logic [2:0] op, input logic a,
                                           input logic b, input logic s);
        case (op)
            3'd0:    return {2'b00, ~a};
            3'd1:    return {2'b00, a & b};
            3'd2:    return {2'b00, a | b};
            3'd3:    return {2'b00, a ^ b};
            3'd4:    return {2'b00, (s ? b : a)};
            3'd5:    return {1'b0, (s ? a : 1'b0), (s ? 1'b0 : a)};
            default: return 3'b100;
        endcase
    endfunction

    // Model: a grant lands one cycle after a pick, operands are taken at the
    // end of the grant cycle, the result is visible two cycles after the grant,
    // and the next pick is only possible three cycles after the grant.
    int         cyc = 0;
    int         g = -100;
    int         free_at = 0;
    int         wid = 0;
    int         mptr = 0;
    int         p_id = 0, m_id = 0;
    logic [1:0] p_out = 2'b00, m_out = 2'b00;
    logic       p_err = 1'b0, m_err = 1'b0;
    bit         model_on = 1'b0;

    always @(posedge clk) begin : model
        int s;
        int idx;
        bit f;
        logic [2:0] r;
        s = cyc;
        if (reset) begin
            model_on = 1'b1;
            g        = -100;
            free_at  = s + 1;
            mptr     = 0;
            m_id     = 0;
            m_out    = 2'b00;
            m_err    = 1'b0;
        end else begin
            if (s == g) begin
                r     = eval_op(req_op[3*wid +: 3], req_a[wid], req_b[wid], req_sel[wid]);
                p_err = r[2];
                p_out = r[1:0];
                p_id  = wid;
                mptr  = (wid + 1) % NREQ;
            end
            if (s == g + 1) begin
                m_id  = p_id;
                m_out = p_out;
                m_err = p_err;
            end
            if (s >= free_at && req != '0) begin
                f = 1'b0;
                for (int k = 0; k < NREQ; k++) begin
                    idx = (mptr + k) % NREQ;
                    if (!f && req[idx]) begin
                        f   = 1'b1;
                        wid = idx;
                    end
                end
                g       = s + 1;
                free_at = s + 4;
            end
        end
        cyc = s + 1;
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (model_on) begin
            check("m_gnt",        32'(gnt),        (cyc == g) ? (32'd1 << wid) : 32'd0);
            check("m_busy",       32'(busy),       32'((cyc >= g) && (cyc <= g + 2)));
            check("m_resp_valid", 32'(resp_valid), 32'(cyc == g + 2));
            check("m_resp_id",    32'(resp_id),    32'(m_id));
            check("m_resp_out",   32'(resp_out),   32'(m_out));
            check("m_resp_err",   32'(resp_err),   32'(m_err));
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait_bound", 32'(n < 20), 32'd1);
    endtask

    task automatic wait_gnt(output logic [NREQ-1:0] gv, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (gnt == '0 && lat < 20);
        gv = gnt;
        check("gnt_wait_bound", 32'(lat < 20), 32'd1);
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (resp_valid !== 1'b1 && lat < 20);
        check("resp_wait_bound", 32'(lat < 20), 32'd1);
    endtask

    task automatic do_single(input int id, input logic [2:0] op, input logic a,
                             input logic b, input logic s,
                             input logic [1:0] eout, input logic eerr);
        logic [NREQ-1:0] gv;
        int lat;
        wait_idle();
        req_op[3*id +: 3] = op;
        req_a[id]   = a;
        req_b[id]   = b;
        req_sel[id] = s;
        req[id]     = 1'b1;
        wait_gnt(gv, lat);
        check("single_gnt", 32'(gv), 32'd1 << id);
        check("gnt_latency", 32'(lat), 32'd1);
        req[id] = 1'b0;
        wait_resp(lat);
        check("resp_latency", 32'(lat), 32'd2);
        check("single_resp_id", 32'(resp_id), 32'(id));
        check("single_resp_out", 32'(resp_out), 32'(eout));
        check("single_resp_err", 32'(resp_err), 32'(eerr));
    endtask

    function automatic int onehot_id(input logic [NREQ-1:0] v);
        int r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [NREQ-1:0] gv;
        int lat;
        int ids[5];
        int gcyc[5];
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};

        reset = 1'b1;
        req = '0; req_a = '0; req_b = '0; req_sel = '0; req_op = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt",        32'(gnt),        32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_out",   32'(resp_out),   32'd0);
        reset = 1'b0;

        // Everyone requesting continuously: strict rotation, 4-cycle spacing.
        wait_idle();
        req_op  = {3'd3, 3'd2, 3'd1, 3'd0};
        req_a   = 4'b1010;
        req_b   = 4'b0110;
        req_sel = 4'b0000;
        req     = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_gnt(gv, lat);
            ids[n]  = onehot_id(gv);
            gcyc[n] = cyc;
        end
        req = '0;
        for (int n = 0; n < 5; n++) begin
            check("rr_order", 32'(ids[n]), 32'(exp_order[n]));
            if (n > 0) check("rr_spacing", 32'(gcyc[n] - gcyc[n-1]), 32'd4);
        end
        wait_resp(lat);

        // Single XOR 1,0 from requester 1.
        do_single(1, 3'd3, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0);
        // DMUX and MUX.
        do_single(0, 3'd5, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
        do_single(0, 3'd5, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0);
        do_single(2, 3'd4, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0);
        // Illegal opcode, then a legal one clears the error flag.
        do_single(3, 3'd7, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1);
        do_single(3, 3'd2, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0);

        // Wrap-around: grant to 2 moves the pointer to 3.
        do_single(2, 3'd1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
        wait_idle();
        req_op[2:0] = 3'd3; req_a[0] = 1'b1; req_b[0] = 1'b1;
        req_op[8:6] = 3'd0; req_a[2] = 1'b0;
        req = 4'b0101;
        wait_gnt(gv, lat);
        check("wrap_first", 32'(gv), 32'b0001);
        req[0] = 1'b0;
        wait_gnt(gv, lat);
        check("wrap_second", 32'(gv), 32'b0100);
        check("wrap_spacing", 32'(lat), 32'd4);
        req[2] = 1'b0;
        wait_resp(lat);
        check("wrap_resp_id", 32'(resp_id), 32'd2);
        check("wrap_resp_out", 32'(resp_out), 32'b01);

        // Reset while executing: no response, pointer back to 0.
        wait_idle();
        req_op[8:6] = 3'd1; req_a[2] = 1'b1; req_b[2] = 1'b1;
        req = 4'b0100;
        wait_gnt(gv, lat);
        check("abort_gnt", 32'(gv), 32'b0100);
        req = '0;
        @(negedge clk);
        check("abort_in_exec", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_valid",    32'(resp_valid), 32'd0);
        check("abort_busy",     32'(busy),       32'd0);
        check("abort_resp_id",  32'(resp_id),    32'd0);
        check("abort_resp_out", 32'(resp_out),   32'd0);
        check("abort_resp_err", 32'(resp_err),   32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_no_resp", 32'(resp_valid), 32'd0);
        req_op[5:3]   = 3'd2; req_a[1] = 1'b0; req_b[1] = 1'b1;
        req_op[11:9]  = 3'd0; req_a[3] = 1'b0;
        req = 4'b1010;
        wait_gnt(gv, lat);
        check("post_reset_first", 32'(gv), 32'b0010);
        req[1] = 1'b0;
        wait_gnt(gv, lat);
        check("post_reset_second", 32'(gv), 32'b1000);
        req = '0;
        wait_resp(lat);
        check("post_reset_resp_out", 32'(resp_out), 32'b01);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
